io_pad_ctrl: RTL and testbench

Fabric-side controller for the tristate pad buffer. It owns the direction and output data of WIDTH bidirectional pins and drives the buffer's in_not_out/din inputs from registers. It inserts bus-turnaround dead cycles on every direction change. On the receive side it synchronises the buffer's dout, detects edges, and latches sticky edge flags for firmware/housekeeping.

---
 rtl/io_pad_pkg.sv | 21 ++
 rtl/io_pad_pin.sv | 139 +++++++++++++
 rtl/io_pad_ctrl.sv | 57 +++++
 tb/tb_io_pad_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/io_pad_pkg.sv
// Shared definitions for the tristate pad controller.
//   pad_state_t : per-pin direction state (IN, TA_OUT, OUT, TA_IN)
//   SYNC_STAGES : depth of the pad-input synchroniser
//   cnt_width() : turnaround counter width for a given TA_CYCLES
package io_pad_pkg;

  typedef enum logic [1:0] {
    IN     = 2'd0,
    TA_OUT = 2'd1,
    OUT    = 2'd2,
    TA_IN  = 2'd3
  } pad_state_t;

  localparam int unsigned SYNC_STAGES = 2;

  // Counter must hold TA_CYCLES+2 (release turnaround load value).
  function automatic int unsigned cnt_width(input int unsigned ta_cycles);
    return $clog2(ta_cycles + 3);
  endfunction

endpackage

// File: rtl/io_pad_pin.sv
// One bidirectional pin: direction FSM with turnaround counter, output data
// register, 2-flop input synchroniser, edge detection and sticky edge flags.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   dir_in                : requested direction (1 = input, 0 = output)
//   out_data              : data to drive
//   clr                   : clear sticky flags
//   dout                  : asynchronous pad value from the buffer
//   in_not_out, din       : registered buffer controls
//   in_sync               : synchronised pad value
//   rise, fall            : one-cycle edge pulses (only while in IN)
//   rise_flag, fall_flag  : sticky edge flags
//   busy                  : pin is in a turnaround state
module io_pad_pin
  import io_pad_pkg::*;
#(
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic dir_in,
  input  logic out_data,
  input  logic clr,
  input  logic dout,
  output logic in_not_out,
  output logic din,
  output logic in_sync,
  output logic rise,
  output logic fall,
  output logic rise_flag,
  output logic fall_flag,
  output logic busy
);

  localparam int unsigned CW = cnt_width(TA_CYCLES);
  localparam logic [CW-1:0] CNT_TA  = CW'(TA_CYCLES);
  localparam logic [CW-1:0] CNT_REL = CW'(TA_CYCLES + 2);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  pad_state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [SYNC_STAGES-1:0] sync;
  logic s_d;
  logic en;

  assign in_sync = sync[SYNC_STAGES-1];
  assign en      = (state == IN);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IN: begin
        if (!dir_in) begin
          if (TA_CYCLES == 0) begin
            state_nxt = OUT;
          end else begin
            state_nxt = TA_OUT;
            cnt_nxt   = CNT_TA;
          end
        end
      end
      TA_OUT: begin
        // Withdrawn request wins over expiry: the pin never drives.
        // cnt may be 0 here when TA_CYCLES = 0 (entered from TA_IN).
        if (dir_in) begin
          state_nxt = IN;
        end else if (cnt <= CNT_ONE) begin
          state_nxt = OUT;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      OUT: begin
        if (dir_in) begin
          state_nxt = TA_IN;
          cnt_nxt   = CNT_REL;
        end
      end
      TA_IN: begin
        if (!dir_in) begin
          state_nxt = TA_OUT;
          cnt_nxt   = CNT_TA;
        end else if (cnt <= CNT_ONE) begin
          state_nxt = IN;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      default: begin
        state_nxt = TA_IN;
        cnt_nxt   = CNT_REL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= TA_IN;
      cnt   <= CNT_REL;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // in_not_out follows the current state one edge later, which gives the
  // k+1+TA_CYCLES drive latency and a one-edge release latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_not_out <= 1'b1;
      busy       <= 1'b1;
      din        <= 1'b0;
    end else begin
      in_not_out <= (state != OUT);
      busy       <= (state_nxt == TA_OUT) || (state_nxt == TA_IN);
      din        <= out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync      <= '0;
      s_d       <= 1'b0;
      rise      <= 1'b0;
      fall      <= 1'b0;
      rise_flag <= 1'b0;
      fall_flag <= 1'b0;
    end else begin
      sync      <= {sync[SYNC_STAGES-2:0], dout};
      s_d       <= in_sync;
      rise      <= in_sync & ~s_d & en;
      fall      <= ~in_sync & s_d & en;
      rise_flag <= rise | (rise_flag & ~clr);
      fall_flag <= fall | (fall_flag & ~clr);
    end
  end

endmodule

// File: rtl/io_pad_ctrl.sv
// Fabric-side controller for WIDTH tristate pad buffers. Each pin is an
// independent io_pad_pin instance.
// Ports:
//   wb_clk_i, wb_rst_i       : clock, synchronous active-high reset
//   dir_in_i                 : requested direction per pin (1 = input)
//   out_data_i               : output data per pin
//   clr_i                    : sticky flag clear per pin
//   dout_i                   : pad value from buffer (asynchronous)
//   in_not_out_o, din_o      : buffer tristate control and drive data
//   in_sync_o                : synchronised pad value
//   rise_o, fall_o           : edge pulses
//   rise_flag_o, fall_flag_o : sticky edge flags
//   busy_o                   : pin in turnaround
module io_pad_ctrl
  import io_pad_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned TA_CYCLES = 1
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] dir_in_i,
  input  logic [WIDTH-1:0] out_data_i,
  input  logic [WIDTH-1:0] clr_i,
  output logic [WIDTH-1:0] in_not_out_o,
  output logic [WIDTH-1:0] din_o,
  input  logic [WIDTH-1:0] dout_i,
  output logic [WIDTH-1:0] in_sync_o,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  output logic [WIDTH-1:0] rise_flag_o,
  output logic [WIDTH-1:0] fall_flag_o,
  output logic [WIDTH-1:0] busy_o
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_pin
    io_pad_pin #(
      .TA_CYCLES(TA_CYCLES)
    ) u_pin (
      .clk       (wb_clk_i),
      .rst       (wb_rst_i),
      .dir_in    (dir_in_i[i]),
      .out_data  (out_data_i[i]),
      .clr       (clr_i[i]),
      .dout      (dout_i[i]),
      .in_not_out(in_not_out_o[i]),
      .din       (din_o[i]),
      .in_sync   (in_sync_o[i]),
      .rise      (rise_o[i]),
      .fall      (fall_o[i]),
      .rise_flag (rise_flag_o[i]),
      .fall_flag (fall_flag_o[i]),
      .busy      (busy_o[i])
    );
  end

endmodule

// File: tb/tb_io_pad_ctrl.sv
// Directed bench for io_pad_ctrl. Three builds share one stimulus:
// a = TA_CYCLES 1, z = TA_CYCLES 0, b = TA_CYCLES 2.
module tb_io_pad_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] dir, odata, clr, dout;

  logic [7:0] ino_a, din_a, sync_a, rise_a, fall_a, rflag_a, fflag_a, busy_a;
  logic [7:0] ino_z, din_z, sync_z, rise_z, fall_z, rflag_z, fflag_z, busy_z;
  logic [7:0] ino_b, din_b, sync_b, rise_b, fall_b, rflag_b, fflag_b, busy_b;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  io_pad_ctrl #(.WIDTH(8), .TA_CYCLES(1)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .dir_in_i(dir), .out_data_i(odata),
    .clr_i(clr), .in_not_out_o(ino_a), .din_o(din_a), .dout_i(dout),
    .in_sync_o(sync_a), .rise_o(rise_a), .fall_o(fall_a),
    .rise_flag_o(rflag_a), .fall_flag_o(fflag_a), .busy_o(busy_a));

  io_pad_ctrl #(.WIDTH(8), .TA_CYCLES(0)) dut_z (
    .wb_clk_i(clk), .wb_rst_i(rst), .dir_in_i(dir), .out_data_i(odata),
    .clr_i(clr), .in_not_out_o(ino_z), .din_o(din_z), .dout_i(dout),
    .in_sync_o(sync_z), .rise_o(rise_z), .fall_o(fall_z),
    .rise_flag_o(rflag_z), .fall_flag_o(fflag_z), .busy_o(busy_z));

  io_pad_ctrl #(.WIDTH(8), .TA_CYCLES(2)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .dir_in_i(dir), .out_data_i(odata),
    .clr_i(clr), .in_not_out_o(ino_b), .din_o(din_b), .dout_i(dout),
    .in_sync_o(sync_b), .rise_o(rise_b), .fall_o(fall_b),
    .rise_flag_o(rflag_b), .fall_flag_o(fflag_b), .busy_o(busy_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance one rising edge and settle; checks and drives happen here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; dir = 8'hFF; dout = 8'hFF; odata = 8'h00; clr = 8'h00;
    tick(); tick();
    // Reset state
    chk("rst_ino_a",  ino_a,  8'hFF);
    chk("rst_ino_z",  ino_z,  8'hFF);
    chk("rst_busy_a", busy_a, 8'hFF);
    chk("rst_sync_a", sync_a, 8'h00);
    chk("rst_din_a",  din_a,  8'h00);
    chk("rst_rise_a", rise_a, 8'h00);
    chk("rst_rflg_a", rflag_a, 8'h00);
    rst = 1'b0;
    tick(); // r+1
    chk("sync_lat1", sync_a, 8'h00);
    tick(); // r+2
    chk("sync_lat2", sync_a, 8'hFF);
    chk("busy_a_r2", busy_a, 8'hFF);
    chk("busy_z_r2", busy_z, 8'h00);
    tick(); // r+3
    chk("busy_a_r3", busy_a, 8'h00);
    chk("rise_mask", rise_a, 8'h00);
    chk("busy_b_r3", busy_b, 8'hFF);
    tick(); // r+4
    chk("rise_mask2", rise_a, 8'h00);
    chk("rflag_mask", rflag_a, 8'h00);
    chk("busy_b_r4", busy_b, 8'h00);
    tick(); tick();

    // Drive request on pin0, sampled at edge k
    dir[0] = 1'b0; odata[0] = 1'b1;
    tick(); // k
    chk("drv_ino_k",  ino_a,  8'hFF);
    chk("drv_busy_k", busy_a, 8'h01);
    chk("drv_din",    din_a,  8'h01);
    chk("drv_z_k",    ino_z,  8'hFF);
    chk("drv_b_busy", busy_b, 8'h01);
    tick(); // k+1
    chk("drv_ino_k1", ino_a,  8'hFF);
    chk("drv_busy_k1", busy_a, 8'h00);
    chk("drv_z_k1",   ino_z,  8'hFE);
    tick(); // k+2
    chk("drv_ino_k2", ino_a,  8'hFE);
    chk("drv_b_k2",   ino_b,  8'hFF);
    tick(); // k+3
    chk("drv_b_k3",   ino_b,  8'hFE);
    tick();

    // Release pin0 with two pad toggles inside the masked window
    dir[0] = 1'b1; dout[0] = 1'b0;
    tick(); // k
    chk("rel_ino_k",  ino_a,  8'hFE);
    chk("rel_busy_k", busy_a, 8'h01);
    dout[0] = 1'b1;
    tick(); // k+1
    chk("rel_ino_k1", ino_a, 8'hFF);
    chk("rel_z_k1",   ino_z, 8'hFF);
    for (int i = 0; i < 4; i++) begin
      chk("rel_mask_r", rise_a & 8'h01, 8'h00);
      chk("rel_mask_f", fall_a & 8'h01, 8'h00);
      tick();
    end
    chk("rel_busy_end", busy_a, 8'h00);
    dout[0] = 1'b0;
    tick(); tick();
    chk("rel_fall_early", fall_a, 8'h00);
    tick();
    chk("rel_fall", fall_a, 8'h01);
    chk("rel_fall_r", rise_a, 8'h00);
    tick();
    chk("rel_fall_end", fall_a, 8'h00);
    chk("rel_fflag", fflag_a, 8'h01);
    clr = 8'h01;
    tick();
    clr = 8'h00;
    chk("rel_fclr", fflag_a, 8'h00);

    // Pin3 edges, flags and clears
    dout[3] = 1'b0;
    tick(); tick(); tick();
    chk("p3_fall0", fall_a, 8'h08);
    tick();
    chk("p3_fflag0", fflag_a, 8'h08);
    clr = 8'h08;
    tick();
    clr = 8'h00;
    chk("p3_fclr0", fflag_a, 8'h00);
    dout[3] = 1'b1;
    tick(); tick(); tick();
    chk("p3_rise", rise_a, 8'h08);
    tick();
    chk("p3_rise_end", rise_a, 8'h00);
    chk("p3_rflag", rflag_a, 8'h08);
    dout[3] = 1'b0;
    tick(); tick(); tick();
    chk("p3_fall", fall_a, 8'h08);
    chk("p3_norise", rise_a, 8'h00);
    tick();
    chk("p3_fflag", fflag_a, 8'h08);
    chk("p3_rflag_hold", rflag_a, 8'h08);
    clr = 8'h08;
    tick();
    clr = 8'h00;
    chk("p3_rclr", rflag_a, 8'h00);
    chk("p3_fclr", fflag_a, 8'h00);
    dout[3] = 1'b1;
    tick(); tick(); tick();
    chk("p3_rise2", rise_a, 8'h08);
    clr = 8'h08;
    tick();
    chk("p3_setwins", rflag_a, 8'h08);
    clr = 8'h00;
    tick();
    chk("p3_setwins_hold", rflag_a, 8'h08);

    // Pin5: output request withdrawn after one cycle
    dir[5] = 1'b0;
    tick(); // h1
    chk("p5_busy_b", busy_b, 8'h20);
    chk("p5_busy_a", busy_a, 8'h20);
    dir[5] = 1'b1;
    tick(); // h2
    chk("p5_busy_b2", busy_b, 8'h00);
    chk("p5_ino_b2",  ino_b,  8'hFF);
    chk("p5_ino_a2",  ino_a,  8'hFF);
    chk("p5_busy_a2", busy_a, 8'h00);
    chk("p5_ino_z2",  ino_z,  8'hDF);
    tick(); // h3
    chk("p5_ino_b3", ino_b, 8'hFF);
    chk("p5_ino_a3", ino_a, 8'hFF);
    chk("p5_ino_z3", ino_z, 8'hFF);

    // Reset while all pins drive
    dir = 8'h00; odata = 8'hA5;
    repeat (5) tick();
    chk("all_drv_a", ino_a, 8'h00);
    chk("all_drv_z", ino_z, 8'h00);
    chk("all_drv_b", ino_b, 8'h00);
    chk("all_din_a", din_a, 8'hA5);
    rst = 1'b1;
    tick();
    chk("mrst_ino_a",  ino_a,  8'hFF);
    chk("mrst_ino_z",  ino_z,  8'hFF);
    chk("mrst_ino_b",  ino_b,  8'hFF);
    chk("mrst_busy_a", busy_a, 8'hFF);
    chk("mrst_din_a",  din_a,  8'h00);
    chk("mrst_rflg_a", rflag_a, 8'h00);
    chk("mrst_rflg_z", rflag_z, 8'h00);
    rst = 1'b0; dir = 8'hFF;
    repeat (5) tick();
    chk("post_busy_a", busy_a, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
